// File: rtl/simt_fetch_pipe.sv
// SIMT instruction fetch: accepts warp offers, issues in-order imem requests, and buffers
// the responses for decode. Global and per-warp flushes retire stale work via kill bits.
module simt_fetch_pipe #(
  parameter int NUM_WARPS       = 8,
  parameter int WARP_SIZE       = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int INSTR_WIDTH     = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int OUT_DEPTH       = 4,
  parameter logic [INSTR_WIDTH-1:0] INSTR_NOP = INSTR_WIDTH'(32'h0000_0013),
  localparam int WID_W = $clog2(NUM_WARPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   warp_valid,
  input  logic [WID_W-1:0]       warp_id,
  input  logic [ADDR_WIDTH-1:0]  warp_pc,
  input  logic [WARP_SIZE-1:0]   warp_mask,
  output logic                   issue_ack,
  input  logic                   flush,
  input  logic                   flush_warp_valid,
  input  logic [WID_W-1:0]       flush_warp_id,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [WID_W-1:0]       out_warp_id,
  output logic [WARP_SIZE-1:0]   out_mask,
  output logic                   busy
);
  localparam int TP_W  = $clog2(MAX_OUTSTANDING);
  localparam int OP_W  = $clog2(OUT_DEPTH);
  localparam int SUM_W = $clog2(MAX_OUTSTANDING + OUT_DEPTH) + 1;

  // Tag FIFO: one entry per outstanding request
  logic [WID_W-1:0]      tag_wid_mem  [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0] tag_pc_mem   [MAX_OUTSTANDING];
  logic [WARP_SIZE-1:0]  tag_mask_mem [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] tag_kill_reg, tag_kill_next;
  logic [TP_W-1:0] tag_wr_reg, tag_rd_reg;
  logic [TP_W:0]   inflight_reg;

  // Output FIFO towards decode
  logic [INSTR_WIDTH-1:0] out_instr_mem [OUT_DEPTH];
  logic [ADDR_WIDTH-1:0]  out_pc_mem    [OUT_DEPTH];
  logic [WID_W-1:0]       out_wid_mem   [OUT_DEPTH];
  logic [WARP_SIZE-1:0]   out_mask_mem  [OUT_DEPTH];
  logic [OUT_DEPTH-1:0]   out_kill_reg, out_kill_next;
  logic [OP_W-1:0] out_wr_reg, out_rd_reg;
  logic [OP_W:0]   out_count_reg;

  logic             resp_take, head_kill, out_push, out_push_kill, out_head_kill, out_pop;
  logic [SUM_W-1:0] occupancy;

  assign resp_take     = imem_rvalid && (inflight_reg != '0);
  assign head_kill     = tag_kill_reg[tag_rd_reg];
  assign out_push      = resp_take && !flush && !head_kill;
  assign out_push_kill = flush_warp_valid && (tag_wid_mem[tag_rd_reg] == flush_warp_id);
  assign out_head_kill = out_kill_reg[out_rd_reg];
  assign out_pop       = (out_count_reg != '0) && (out_head_kill || out_ready);
  // Killed entries still occupy space until removed, so they count here too
  assign occupancy     = SUM_W'(inflight_reg) + SUM_W'(out_count_reg);

  assign issue_ack = !rst && enable && warp_valid && imem_ready && !flush &&
                     !(flush_warp_valid && (flush_warp_id == warp_id)) &&
                     (inflight_reg < (TP_W+1)'(MAX_OUTSTANDING)) &&
                     (occupancy < SUM_W'(OUT_DEPTH));
  assign imem_req  = issue_ack;
  assign imem_addr = warp_pc;

  generate
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_tag_kill
      assign tag_kill_next[gi] =
        (issue_ack && (tag_wr_reg == TP_W'(gi))) ? 1'b0 :
        (flush || (flush_warp_valid && (tag_wid_mem[gi] == flush_warp_id))) ? 1'b1 :
        tag_kill_reg[gi];
    end
    for (genvar gi = 0; gi < OUT_DEPTH; gi++) begin : g_out_kill
      assign out_kill_next[gi] =
        (out_push && (out_wr_reg == OP_W'(gi))) ? out_push_kill :
        (flush_warp_valid && (out_wid_mem[gi] == flush_warp_id)) ? 1'b1 :
        out_kill_reg[gi];
    end
  endgenerate

  // Payload storage needs no reset; validity is carried by pointers and counts
  always_ff @(posedge clk) begin
    if (issue_ack) begin
      tag_wid_mem[tag_wr_reg]  <= warp_id;
      tag_pc_mem[tag_wr_reg]   <= warp_pc;
      tag_mask_mem[tag_wr_reg] <= warp_mask;
    end
    if (out_push) begin
      out_instr_mem[out_wr_reg] <= imem_rdata;
      out_pc_mem[out_wr_reg]    <= tag_pc_mem[tag_rd_reg];
      out_wid_mem[out_wr_reg]   <= tag_wid_mem[tag_rd_reg];
      out_mask_mem[out_wr_reg]  <= tag_mask_mem[tag_rd_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_kill_reg  <= '0;
      tag_wr_reg    <= '0;
      tag_rd_reg    <= '0;
      inflight_reg  <= '0;
      out_kill_reg  <= '0;
      out_wr_reg    <= '0;
      out_rd_reg    <= '0;
      out_count_reg <= '0;
    end else begin
      tag_kill_reg <= tag_kill_next;
      tag_wr_reg   <= tag_wr_reg + TP_W'(issue_ack);
      tag_rd_reg   <= tag_rd_reg + TP_W'(resp_take);
      inflight_reg <= inflight_reg + (TP_W+1)'(issue_ack) - (TP_W+1)'(resp_take);
      out_kill_reg <= out_kill_next;
      out_wr_reg   <= out_wr_reg + OP_W'(out_push);
      if (flush) begin
        out_rd_reg    <= out_wr_reg;
        out_count_reg <= '0;
      end else begin
        out_rd_reg    <= out_rd_reg + OP_W'(out_pop);
        out_count_reg <= out_count_reg + (OP_W+1)'(out_push) - (OP_W+1)'(out_pop);
      end
    end
  end

  assign out_valid   = !rst && (out_count_reg != '0) && !out_head_kill;
  assign out_instr   = out_valid ? out_instr_mem[out_rd_reg] : INSTR_NOP;
  assign out_pc      = out_valid ? out_pc_mem[out_rd_reg]    : '0;
  assign out_warp_id = out_valid ? out_wid_mem[out_rd_reg]   : '0;
  assign out_mask    = out_valid ? out_mask_mem[out_rd_reg]  : '0;
  assign busy        = !rst && ((inflight_reg != '0) || (out_count_reg != '0));
endmodule
